// File: rtl/ram_wport_arbiter.sv
// ram_wport_arbiter: round-robin write-port arbiter with lock and a registered RAM write stage
module ram_wport_arbiter #(
  parameter int ENTRY_CNT = 32,
  parameter int ENTRY_WIDTH = 32,
  parameter int N_REQ = 4,
  localparam int AW = $clog2(ENTRY_CNT),
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ-1:0]                  req_lock,
  input  logic [N_REQ-1:0][AW-1:0]          req_adr,
  input  logic [N_REQ-1:0][ENTRY_WIDTH-1:0] req_dat,
  output logic [N_REQ-1:0]                  req_ready,
  input  logic                              stall,
  output logic                              ram_wr,
  output logic [AW-1:0]                     ram_wadr,
  output logic [ENTRY_WIDTH-1:0]            ram_wdat,
  output logic [IW-1:0]                     grant_id,
  output logic                              locked,
  output logic [15:0]                       wr_count
);
  typedef enum logic {IDLE, LOCKED} state_e;
  state_e state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, hs_id, idx;
  logic [AW-1:0] ram_wadr_q, ram_wadr_d;
  logic [ENTRY_WIDTH-1:0] ram_wdat_q, ram_wdat_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic [IW:0] sum;
  logic ram_wr_q, ram_wr_d, hs, found;
  // grant: first valid requester at or after rr_ptr, or only the owner while locked
  always_comb begin
    req_ready = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
      idx = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ)) : IW'(sum);
      if (!found && req_valid[idx]) begin
        req_ready[idx] = 1'b1;
        found = 1'b1;
      end
    end
    if (state_q == LOCKED) begin
      req_ready = '0;
      req_ready[owner_q] = req_valid[owner_q];
    end
    if (stall || !rst_n) req_ready = '0;
  end
  // handshake decode: at most one requester is ready, so the last match is the only one
  always_comb begin
    hs = 1'b0;
    hs_id = '0;
    for (int i = 0; i < N_REQ; i++)
      if (req_valid[i] && req_ready[i]) begin
        hs = 1'b1;
        hs_id = IW'(i);
      end
  end
  // next state: write stage capture, rotation pointer, lock FSM, saturating beat counter
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_ptr_d = hs ? ((hs_id == IW'(N_REQ-1)) ? '0 : hs_id + 1'b1) : rr_ptr_q;
    ram_wr_d = hs;
    ram_wadr_d = hs ? req_adr[hs_id] : ram_wadr_q;
    ram_wdat_d = hs ? req_dat[hs_id] : ram_wdat_q;
    grant_id_d = hs ? hs_id : grant_id_q;
    wr_count_d = (ram_wr_q && wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;
    if (state_q == IDLE) begin
      if (hs && req_lock[hs_id]) begin
        state_d = LOCKED;
        owner_d = hs_id;
      end
    end else if (!req_valid[owner_q] || (hs && !req_lock[hs_id])) state_d = IDLE;
  end
  // state registers; reset also kills any in-flight write beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_ptr_q <= '0;
      ram_wr_q <= 1'b0;
      ram_wadr_q <= '0;
      ram_wdat_q <= '0;
      grant_id_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      ram_wr_q <= ram_wr_d;
      ram_wadr_q <= ram_wadr_d;
      ram_wdat_q <= ram_wdat_d;
      grant_id_q <= grant_id_d;
      wr_count_q <= wr_count_d;
    end
  end
  assign ram_wr = ram_wr_q;
  assign ram_wadr = ram_wadr_q;
  assign ram_wdat = ram_wdat_q;
  assign grant_id = grant_id_q;
  assign locked = (state_q == LOCKED);
  assign wr_count = wr_count_q;
endmodule

// File: tb/tb_ram_wport_arbiter.sv
// tb_ram_wport_arbiter: scoreboard bench for the round-robin RAM write-port arbiter
module tb_ram_wport_arbiter;
  localparam int N = 4;
  typedef struct packed {
    logic [4:0] a;
    logic [31:0] d;
    logic [1:0] id;
  } beat_t;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0;
  logic [N-1:0] req_valid = '0, req_lock = '0, req_ready;
  logic [N-1:0][4:0] req_adr = '0;
  logic [N-1:0][31:0] req_dat = '0;
  logic ram_wr, locked;
  logic [4:0] ram_wadr;
  logic [31:0] ram_wdat;
  logic [1:0] grant_id;
  logic [15:0] wr_count;
  beat_t q[$];
  beat_t e;
  int n_cmp = 0, n_err = 0;
  int m_rr = 0, m_own = 0;
  bit m_lk = 0, m_wr = 0;
  logic [15:0] m_cnt = '0;

  ram_wport_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_lock(req_lock),
    .req_adr(req_adr), .req_dat(req_dat), .req_ready(req_ready), .stall(stall),
    .ram_wr(ram_wr), .ram_wadr(ram_wadr), .ram_wdat(ram_wdat), .grant_id(grant_id),
    .locked(locked), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    int g;
    int idx;
    logic [N-1:0] exp_ready;
    #1;
    g = -1;
    exp_ready = '0;
    if (!stall) begin
      if (m_lk) begin
        if (req_valid[m_own]) g = m_own;
      end else
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (g < 0 && req_valid[idx]) g = idx;
        end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("ready", req_ready, exp_ready);
    if (m_wr && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (g >= 0) begin
      q.push_back('{a: req_adr[g], d: req_dat[g], id: 2'(g)});
      m_rr = (g + 1) % N;
      m_lk = req_lock[g];
      m_own = g;
    end else if (m_lk && !req_valid[m_own]) m_lk = 0;
    m_wr = (g >= 0);
    @(posedge clk);
    #1;
    chk("wr", ram_wr, m_wr);
    if (ram_wr) begin
      chk("qsz", q.size(), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("adr", ram_wadr, e.a);
        chk("dat", ram_wdat, e.d);
        chk("gid", grant_id, e.id);
      end
    end
    chk("cnt", wr_count, m_cnt);
    chk("locked", locked, m_lk);
  endtask

  task automatic run(input logic [N-1:0] v, input logic [N-1:0] l, input logic s, input int n);
    for (int c = 0; c < n; c++) begin
      req_valid = v;
      req_lock = l;
      stall = s;
      for (int i = 0; i < N; i++) begin
        req_adr[i] = 5'($urandom);
        req_dat[i] = $urandom;
      end
      cycle();
    end
  endtask

  initial begin
    req_valid = 4'b1111;
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_wr", ram_wr, 0);
    chk("rst_adr", ram_wadr, 0);
    chk("rst_dat", ram_wdat, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_locked", locked, 0);
    chk("rst_cnt", wr_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(4'b1111, 4'b0000, 1'b0, 9);
    chk("t1_cnt8", wr_count, 8);
    req_valid = 4'b0010;
    req_lock = '0;
    req_adr[1] = 5'd5;
    req_dat[1] = 32'hDEADBEEF;
    cycle();
    chk("t2_adr", ram_wadr, 5);
    chk("t2_dat", ram_wdat, 32'hDEADBEEF);
    chk("t2_gid", grant_id, 1);
    run(4'b0100, 4'b0100, 1'b0, 1);
    run(4'b1101, 4'b0100, 1'b0, 2);
    chk("t3_locked", locked, 1);
    run(4'b1101, 4'b0000, 1'b0, 1);
    chk("t3_gid_last", grant_id, 2);
    run(4'b1001, 4'b0000, 1'b0, 2);
    chk("t3_gid_after", grant_id, 0);
    run(4'b1111, 4'b0000, 1'b1, 3);
    run(4'b1111, 4'b0000, 1'b0, 4);
    run(4'b0010, 4'b0010, 1'b0, 1);
    chk("t5_locked", locked, 1);
    run(4'b0100, 4'b0000, 1'b0, 1);
    chk("t5_unlocked", locked, 0);
    run(4'b0100, 4'b0000, 1'b0, 1);
    chk("t5_gid", grant_id, 2);
    for (int c = 0; c < 300; c++)
      run(4'($urandom), 4'($urandom), ($urandom_range(0, 4) == 0), 1);
    run(4'b1000, 4'b0000, 1'b0, 65540);
    chk("t6_sat", wr_count, 16'hFFFF);
    chk("t6_wr", ram_wr, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_wr", ram_wr, 0);
    chk("t6_rst_cnt", wr_count, 0);
    chk("t6_rst_ready", req_ready, 0);
    chk("t6_rst_locked", locked, 0);
    q.delete();
    m_rr = 0;
    m_lk = 0;
    m_wr = 0;
    m_cnt = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(4'b1111, 4'b0000, 1'b0, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_wport_arbiter.md
Name: ram_wport_arbiter

Overview:
- Shares the single write port of the multiport register/RAM array between N_REQ independent writers (e.g. ALU, LSU and CSR writeback).
- Round-robin arbitration with optional per-requester lock, so one writer can hold the port for a back-to-back burst.
- One registered output stage drives the RAM write port directly.
- Also exports a saturating count of committed writes for performance monitoring.

Parameters:
- ENTRY_CNT, 32: number of RAM entries. AW = $clog2(ENTRY_CNT).
- ENTRY_WIDTH, 32: data width per entry.
- N_REQ, 4: number of requesters, ≥2. IW = $clog2(N_REQ).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  [N_REQ-1:0]  write request present per requester.
- req_lock  input  [N_REQ-1:0]  requester wants to keep the port after this beat.
- req_adr  input  [N_REQ-1:0][AW-1:0]  write address per requester.
- req_dat  input  [N_REQ-1:0][ENTRY_WIDTH-1:0]  write data per requester.
- req_ready  output  [N_REQ-1:0]  one-hot or zero grant; handshake when valid&ready.
- stall  input  1  blocks all new grants while high.
- ram_wr  output  1  RAM write enable (registered).
- ram_wadr  output  AW  RAM write address (registered).
- ram_wdat  output  ENTRY_WIDTH  RAM write data (registered).
- grant_id  output  IW  index of the requester behind the current ram_wr beat (registered).
- locked  output  1  high while in LOCKED state.
- wr_count  output  16  saturating count of ram_wr beats.

Behaviour:

Reset (rst_n low, async):
- ram_wr=0, ram_wadr=0, ram_wdat=0, grant_id=0, locked=0, wr_count=0.
- State=IDLE, rr_ptr=0.
- req_ready is combinational: all 0 while in reset.

Grant (combinational, single cycle):
- If stall=1, req_ready=0.
- In IDLE: scan valid requesters from rr_ptr upward, modulo N_REQ. The first valid one gets req_ready. With no valid requester, req_ready=0.
- In LOCKED: only the owner can get req_ready, and only when req_valid[owner]=1. All other requesters see 0.
- req_ready never depends on req_lock, req_adr or req_dat.

Handshake at posedge (req_valid[i]&req_ready[i]):
- Registers: ram_wr=1, ram_wadr=req_adr[i], ram_wdat=req_dat[i], grant_id=i.
- Latency: 1 cycle from handshake edge to ram_wr visible. The RAM commits at the following edge.
- rr_ptr becomes (i+1) mod N_REQ; wrap from N_REQ-1 to 0.
- Without a handshake: ram_wr=0 next cycle. ram_wadr, ram_wdat and grant_id hold their values.

State machine:
- IDLE→LOCKED: handshake by i with req_lock[i]=1. owner=i, locked=1 next cycle.
- LOCKED→LOCKED: owner handshakes with req_lock=1.
- LOCKED→IDLE: owner handshakes with req_lock=0. That beat is still written.
- LOCKED→IDLE: req_valid[owner]=0 in any cycle (abandon). No write occurs.
- stall=1 while LOCKED: stay LOCKED, no grant. The abandon rule still applies.
- rr_ptr advances on every handshake, including locked beats. After a lock ends, priority starts at owner+1.

wr_count:
- +1 on every cycle in which ram_wr=1.
- Saturates at 16'hFFFF with no wrap.

Boundary cases:
- All requesters valid every cycle: each is granted exactly once per N_REQ cycles.
- Single requester continuously valid: granted every cycle, one write per cycle.
- Reset asserted mid-lock: returns to IDLE immediately. The in-flight ram_wr is dropped (forced 0).
- Valid dropped without a handshake: allowed, and no write results.

Test Plan:
1. Reset, then req_valid=4'b1111 held, stall=0, lock=0 → grants cycle 0,1,2,3,0…; ram_wr=1 from cycle 1 with grant_id 0,1,2,3,0; wr_count=8 after 8 beats.
2. Only req1 valid, adr=5, dat=32'hDEADBEEF → req_ready=4'b0010 same cycle; next cycle ram_wr=1, ram_wadr=5, ram_wdat=DEADBEEF, grant_id=1.
3. req2 lock=1 for 3 beats then lock=0 on the 4th, with req0 and req3 also valid → 4 consecutive grants to 2, locked=1 during the burst; next grant goes to 3, then 0.
4. stall=1 for 3 cycles with all valid → req_ready=0, ram_wr=0 on the following cycles; after release, grant resumes from rr_ptr with no skipped requester.
5. In LOCKED with owner=1, drop req_valid[1] → locked=0 next cycle, no write, next grant to 2 if valid.
6. Preload wr_count to 16'hFFFE via 65534 beats, then 3 more beats → wr_count stays 16'hFFFF; rst_n pulse mid-beat → ram_wr=0, wr_count=0 immediately.
